gcd_request_sequencer: RTL and testbench

- Upstream front-end for the GCD core (controlpath plus datapath).
- Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Issues one pair at a time to the core with go, waits for the core's gld, captures the result, and returns it on a valid/ready output stream.
- Handles the cases the core cannot handle: zero operands, a hung core, and the core's sticky done state (which needs a clr pulse before each new job).

---
 rtl/gcd_request_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_gcd_request_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_request_sequencer.sv
// gcd_request_sequencer: front-end for the GCD core. Buffers operand pairs in a
// small FIFO, runs one job at a time on the core (clr / go / gld handshake),
// bypasses zero-operand jobs, aborts hung jobs and returns results on a
// valid/ready stream.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RESTART   | core_clr high for one cycle, clears the core's sticky done
// IDLE      | pop next pair; zero operands resolved here without the core
// LOAD      | core_go high for one cycle, timeout counter cleared
// WAIT      | wait for core_gld or the timeout compare
// CAPTURE   | register core_gout as the result
// RESULT    | out_valid held until out_ready
module gcd_request_sequencer #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic             core_clr,
  output logic             core_go,
  output logic [WIDTH-1:0] core_xin,
  output logic [WIDTH-1:0] core_yin,
  input  logic             core_gld,
  input  logic [WIDTH-1:0] core_gout,
  output logic             busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TMO_CNT  = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_RESTART,
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CAPTURE,
    S_RESULT
  } state_t;

  state_t                 state;
  logic [2*WIDTH-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;
  logic                   live;
  logic                   push;
  logic                   pop;
  logic [WIDTH-1:0]       head_x;
  logic [WIDTH-1:0]       head_y;
  logic [WIDTH-1:0]       op_x;
  logic [WIDTH-1:0]       op_y;
  logic [CW-1:0]          cnt;
  logic                   used;

  // live stays low through reset so in_ready and busy read 0 while clr_n is low
  assign in_ready = live & (count != FULL_CNT);
  assign push     = in_valid & in_ready;
  assign pop      = (state == S_IDLE) & (count != '0);
  assign head_x   = mem[rd_ptr][2*WIDTH-1:WIDTH];
  assign head_y   = mem[rd_ptr][WIDTH-1:0];
  assign core_xin = op_x;
  assign core_yin = op_y;
  assign busy     = live & ((state != S_IDLE) | (count != '0));

  // out-of-reset flag
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  // FIFO storage; contents are don't-care while count is zero
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_x, in_y};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // job sequencer with registered core and result outputs
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= S_RESTART;
      core_clr  <= 1'b1;
      core_go   <= 1'b0;
      out_valid <= 1'b0;
      out_gcd   <= '0;
      out_err   <= 1'b0;
      op_x      <= '0;
      op_y      <= '0;
      cnt       <= '0;
      used      <= 1'b0;
    end else begin
      case (state)
        S_RESTART: begin
          core_clr <= 1'b0;
          state    <= S_IDLE;
        end
        S_IDLE: begin
          if (count != '0) begin
            op_x <= head_x;
            op_y <= head_y;
            if (head_x == '0 && head_y == '0) begin
              out_gcd   <= '0;
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              used      <= 1'b0;
              state     <= S_RESULT;
            end else if (head_x == '0 || head_y == '0) begin
              out_gcd   <= head_x | head_y;
              out_err   <= 1'b0;
              out_valid <= 1'b1;
              used      <= 1'b0;
              state     <= S_RESULT;
            end else begin
              used    <= 1'b1;
              core_go <= 1'b1;
              state   <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          // a gld still high here is left over from the previous job; not looked at
          core_go <= 1'b0;
          cnt     <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (core_gld) begin
            state <= S_CAPTURE;
          end else if (cnt == TMO_CNT) begin
            out_gcd   <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= S_RESULT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_CAPTURE: begin
          out_gcd   <= core_gout;
          out_err   <= 1'b0;
          out_valid <= 1'b1;
          state     <= S_RESULT;
        end
        S_RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (used) begin
              core_clr <= 1'b1;
              state    <= S_RESTART;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          core_clr <= 1'b1;
          core_go  <= 1'b0;
          state    <= S_RESTART;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_request_sequencer.sv
// Directed bench for gcd_request_sequencer: a behavioural GCD core stand-in,
// one instance with the default timeout and one with TIMEOUT=15.
module tb_gcd_request_sequencer;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [15:0] in_x, in_y, out_gcd;
  logic        core_clr, core_go, busy;
  logic [15:0] core_xin, core_yin;
  logic        core_gld = 1'b0;
  logic [15:0] core_gout = 16'd0;

  logic        t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_out_err;
  logic [15:0] t_in_x, t_in_y, t_out_gcd;
  logic        t_core_clr, t_core_go, t_busy;
  logic [15:0] t_core_xin, t_core_yin;
  logic        t_core_gld = 1'b0;
  logic [15:0] t_core_gout = 16'd0;

  int n_cmp = 0;
  int n_bad = 0;
  int go_cnt = 0;
  int clr_cnt = 0;
  int core_delay = 20;
  logic gld_block = 1'b0;
  logic m_run = 1'b0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  gcd_request_sequencer u_dut (
    .clk(clk), .clr_n(clr_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd), .out_err(out_err),
    .core_clr(core_clr), .core_go(core_go), .core_xin(core_xin), .core_yin(core_yin),
    .core_gld(core_gld), .core_gout(core_gout), .busy(busy)
  );

  gcd_request_sequencer #(.TIMEOUT(15)) u_tmo (
    .clk(clk), .clr_n(clr_n),
    .in_valid(t_in_valid), .in_ready(t_in_ready), .in_x(t_in_x), .in_y(t_in_y),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .out_gcd(t_out_gcd), .out_err(t_out_err),
    .core_clr(t_core_clr), .core_go(t_core_go), .core_xin(t_core_xin), .core_yin(t_core_yin),
    .core_gld(t_core_gld), .core_gout(t_core_gout), .busy(t_busy)
  );

  function automatic logic [15:0] gcd_f(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a;
    y = b;
    while (y != 16'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // GCD core stand-in: sticky gld after core_delay cycles, cleared by core_clr
  always @(posedge clk) begin
    if (core_clr) begin
      core_gld <= 1'b0;
      m_run    <= 1'b0;
      m_cnt    <= 0;
    end else if (core_go) begin
      m_run <= 1'b1;
      m_cnt <= 0;
    end else if (m_run && !gld_block) begin
      if (m_cnt == core_delay - 1) begin
        core_gld  <= 1'b1;
        core_gout <= gcd_f(core_xin, core_yin);
        m_run     <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // count cycles with go / clr asserted
  always @(posedge clk) begin
    if (core_go)  go_cnt  <= go_cnt + 1;
    if (core_clr) clr_cnt <= clr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the pair was taken
  task automatic push(input logic [15:0] x, input logic [15:0] y);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic accept(input string tag, input logic [15:0] g, input logic e);
    check({tag, "_gcd"}, 32'(out_gcd), 32'(g));
    check({tag, "_err"}, 32'(out_err), 32'(e));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] bx [6] = '{16'd12, 16'd9, 16'd35, 16'd100, 16'd21, 16'd18};
  logic [15:0] by [6] = '{16'd8, 16'd6, 16'd14, 16'd75, 16'd14, 16'd27};
  logic [15:0] bg [6] = '{16'd4, 16'd3, 16'd7, 16'd25, 16'd7, 16'd9};

  initial begin
    int n, g0, c0, res_done, res_at_push;
    clr_n = 1'b0;
    in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0;
    t_in_valid = 1'b0; t_in_x = '0; t_in_y = '0; t_out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_core_go", 32'(core_go), 32'd0);
    check("rst_core_clr", 32'(core_clr), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_gcd", 32'(out_gcd), 32'd0);
    check("rst_t_in_ready", 32'(t_in_ready), 32'd0);
    clr_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_busy", 32'(busy), 32'd0);
    check("rel_core_clr", 32'(core_clr), 32'd0);

    // basic job
    core_delay = 20;
    push(16'd48, 16'd18);
    n = 0;
    while (!core_go && n < 20) begin @(negedge clk); n++; end
    check("t1_go", 32'(core_go), 32'd1);
    check("t1_xin", 32'(core_xin), 32'd48);
    check("t1_yin", 32'(core_yin), 32'd18);
    @(negedge clk);
    check("t1_go_pulse", 32'(core_go), 32'd0);
    wait_valid("t1");
    check("t1_xin_held", 32'(core_xin), 32'd48);
    check("t1_yin_held", 32'(core_yin), 32'd18);
    check("t1_go_once", 32'(go_cnt), 32'd1);
    accept("t1", 16'd6, 1'b0);
    check("t1_clr_hi", 32'(core_clr), 32'd1);
    @(negedge clk);
    check("t1_clr_lo", 32'(core_clr), 32'd0);

    // zero bypass
    g0 = go_cnt;
    c0 = clr_cnt;
    push(16'd0, 16'd7);
    push(16'd0, 16'd0);
    wait_valid("t2a");
    accept("t2a", 16'd7, 1'b0);
    wait_valid("t2b");
    accept("t2b", 16'd0, 1'b1);
    repeat (3) @(negedge clk);
    check("t2_no_go", 32'(go_cnt), 32'(g0));
    check("t2_no_clr", 32'(clr_cnt), 32'(c0));

    // backpressure in: core held off, FIFO fills, sixth pair waits for a pop
    core_delay = 3;
    gld_block = 1'b1;
    for (int i = 0; i < 5; i++) push(bx[i], by[i]);
    check("t3_full", 32'(in_ready), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    res_done = 0;
    res_at_push = -1;
    fork
      begin
        push(bx[5], by[5]);
        res_at_push = res_done;
      end
      begin
        repeat (4) @(negedge clk);
        check("t3_still_full", 32'(in_ready), 32'd0);
        gld_block = 1'b0;
        for (int i = 0; i < 6; i++) begin
          wait_valid($sformatf("t3_%0d", i));
          accept($sformatf("t3_%0d", i), bg[i], 1'b0);
          res_done++;
        end
      end
    join
    check("t3_held_after_pop", 32'(res_at_push >= 1), 32'd1);

    // backpressure out
    core_delay = 5;
    repeat (2) @(negedge clk);
    push(16'd54, 16'd24);
    wait_valid("t4");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_gcd", 32'(out_gcd), 32'd6);
    end
    accept("t4", 16'd6, 1'b0);
    check("t4_clr", 32'(core_clr), 32'd1);

    // timeout on the TIMEOUT=15 instance
    check("t5_in_ready", 32'(t_in_ready), 32'd1);
    t_in_valid = 1'b1; t_in_x = 16'd10; t_in_y = 16'd4;
    @(negedge clk);
    t_in_valid = 1'b0;
    n = 0;
    while (!t_core_go && n < 10) begin @(negedge clk); n++; end
    check("t5_go", 32'(t_core_go), 32'd1);
    n = 0;
    while (!t_out_valid && n < 100) begin @(negedge clk); n++; end
    check("t5_latency", 32'(n), 32'd17);
    check("t5_gcd", 32'(t_out_gcd), 32'd0);
    check("t5_err", 32'(t_out_err), 32'd1);
    t_out_ready = 1'b1;
    @(negedge clk);
    t_out_ready = 1'b0;
    check("t5_drop", 32'(t_out_valid), 32'd0);
    check("t5_clr_hi", 32'(t_core_clr), 32'd1);
    @(negedge clk);
    check("t5_clr_lo", 32'(t_core_clr), 32'd0);

    // reset mid-WAIT with two pairs queued
    gld_block = 1'b1;
    core_delay = 3;
    repeat (2) @(negedge clk);
    push(16'd48, 16'd18);
    push(16'd10, 16'd5);
    push(16'd7, 16'd3);
    repeat (3) @(negedge clk);
    check("t6_busy", 32'(busy), 32'd1);
    #2 clr_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_go", 32'(core_go), 32'd0);
    check("t6_rst_clr", 32'(core_clr), 32'd1);
    check("t6_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    gld_block = 1'b0;
    @(negedge clk);
    check("t6_in_ready", 32'(in_ready), 32'd1);
    check("t6_busy_idle", 32'(busy), 32'd0);
    g0 = go_cnt;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("t6_no_stale", 32'(n), 32'd0);
    check("t6_no_go", 32'(go_cnt), 32'(g0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
